uart_frame_decoder: RTL and testbench
=====================================

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1_000_000, maximum idle gap between bytes inside a frame (10 ms at 100 MHz).
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1: single clock for the whole block (100 MHz system clock).
- reset, in, 1: synchronous, active-high.
- io_rxByte_valid, in, 1: one-cycle pulse per received UART byte.
- io_rxByte_bits, in, 8: received byte; valid only while io_rxByte_valid is high.
- io_frame_ready, in, 1: consumer accepts the held frame.
- io_frame_valid, out, 1: a decoded frame is held.
- io_frame_cmd, out, 8: command byte.
- io_frame_len, out, 5: payload length, 0..16.
- io_frame_payload, out, 128: payload byte i at bits [8i+7:8i]; unused bytes are 0.
- io_errChecksum, out, 1: one-cycle pulse on checksum mismatch.
- io_errLength, out, 1: one-cycle pulse on length greater than 16.
- io_errTimeout, out, 1: one-cycle pulse on inter-byte timeout.
- io_dropCount, out, 8: count of good frames dropped because the output was busy; saturates at 255.
- io_busy, out, 1: high whenever the state is not IDLE.

Function
REQ-003 Frame format: SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK. CHK is the XOR of CMD, LEN and all payload bytes.
REQ-004 The state machine has states IDLE, CMD, LEN, PAYLOAD and CHECK. The state advances only on cycles where io_rxByte_valid is high.
REQ-005 In IDLE:
- a byte equal to SYNC_BYTE moves the state to CMD;
- any other byte is ignored.
REQ-006 In CMD, the byte is stored as cmd, the running XOR is set to that byte, and the state moves to LEN.
REQ-007 In LEN:
- LEN > 16 pulses io_errLength and returns to IDLE;
- LEN = 0 goes directly to CHECK;
- otherwise the state moves to PAYLOAD.
- In all cases the byte is XORed into the running XOR.
REQ-008 In PAYLOAD, each byte is written to the next byte slot of a 16-byte staging buffer and XORed into the running XOR. The state moves to CHECK after LEN bytes.
REQ-009 At the start of each frame, in the CMD state, the staging buffer is cleared to 0.
REQ-010 In CHECK:
- if the byte does not equal the running XOR, io_errChecksum pulses and the state returns to IDLE;
- otherwise the frame is good and the state returns to IDLE.
REQ-011 Good-frame output: the output registers (cmd, len, payload) load and io_frame_valid rises in the cycle after the CHK byte. Latency is 1 cycle.
REQ-012 Handshake:
- io_frame_valid and the output data stay stable until a cycle where io_frame_valid and io_frame_ready are both high;
- io_frame_valid falls in the next cycle unless a new frame loads in that same cycle.
REQ-013 Output register busy: if a good frame completes while io_frame_valid is high and io_frame_ready is low, the new frame is discarded, the held frame is kept, and io_dropCount increments, saturating at 255.
REQ-014 Simultaneous accept and completion: if io_frame_ready is high in the completion cycle, the held frame counts as accepted, the new frame loads, and io_frame_valid stays high. No drop is counted.
REQ-015 Timeout counter:
- counts clock cycles while the state is not IDLE;
- clears on every io_rxByte_valid;
- on reaching TIMEOUT_CYCLES it pulses io_errTimeout for one cycle, returns to IDLE and clears.
- A byte arriving in the same cycle as the timeout is treated as an IDLE-state byte.
REQ-016 At most one error pulse is asserted per cycle. Error pulses never touch the output registers.
REQ-017 A SYNC_BYTE value inside a frame is treated as ordinary data. There is no resynchronisation mid-frame.

Reset
REQ-018 When reset is high at a clock edge:
- state goes to IDLE;
- io_frame_valid = 0, io_frame_cmd = 0, io_frame_len = 0, io_frame_payload = 0;
- all error pulses = 0;
- io_dropCount = 0, io_busy = 0;
- running XOR, timeout counter and staging buffer are cleared.
REQ-019 Reset asserted mid-frame or while a frame is held discards everything. There is no output until a new SYNC_BYTE arrives after reset is released.

Verification
REQ-020 Bytes A5 01 02 10 20 33, with ready held high -> frame_valid for 1 cycle, cmd = 01, len = 2, payload = 0x2010, no error pulses.
REQ-021 Bytes A5 07 00 07, then bytes A5 07 00 06 -> first: valid frame with len = 0 and payload = 0; second: io_errChecksum pulse and no frame.
REQ-022 Bytes A5 01 11 -> io_errLength pulse and return to IDLE. Then bytes A5 01 01 FF FF -> frame with cmd = 01, payload byte0 = FF.
REQ-023 Ready held low, then two good frames back to back -> first frame held, io_dropCount = 1. Raise ready -> valid falls; the first frame's data is observed.
REQ-024 Bytes A5 01, then no bytes for TIMEOUT_CYCLES (bench overrides to 100) -> io_errTimeout pulses at cycle 100 after the last byte, io_busy = 0. Reset asserted between payload bytes -> no frame and no error pulses.

Source files
------------

// File: rtl/uart_frame_decoder_if.sv
// Byte-in / frame-out bundle for uart_frame_decoder.
// The decoder uses the slave view; whatever feeds bytes and consumes frames uses the master view.
interface uart_frame_decoder_if;
   logic         io_rxByte_valid;
   logic [7:0]   io_rxByte_bits;
   logic         io_frame_ready;
   logic         io_frame_valid;
   logic [7:0]   io_frame_cmd;
   logic [4:0]   io_frame_len;
   logic [127:0] io_frame_payload;
   logic         io_errChecksum;
   logic         io_errLength;
   logic         io_errTimeout;
   logic [7:0]   io_dropCount;
   logic         io_busy;

   modport master (
      output io_rxByte_valid, io_rxByte_bits, io_frame_ready,
      input  io_frame_valid, io_frame_cmd, io_frame_len, io_frame_payload,
      input  io_errChecksum, io_errLength, io_errTimeout, io_dropCount, io_busy
   );

   modport slave (
      input  io_rxByte_valid, io_rxByte_bits, io_frame_ready,
      output io_frame_valid, io_frame_cmd, io_frame_len, io_frame_payload,
      output io_errChecksum, io_errLength, io_errTimeout, io_dropCount, io_busy
   );
endinterface

// File: rtl/uart_frame_decoder.sv
// Parses SYNC/CMD/LEN/payload/CHK frames from a UART byte stream and holds each good
// frame in a valid/ready output register, reporting checksum, length and timeout errors.
module uart_frame_decoder #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                clock,
   input  logic                reset,
   uart_frame_decoder_if.slave bus
);
   localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_LEN,
      ST_PAYLOAD,
      ST_CHECK
   } state_e;

   state_e           state_q, state_d, eff_state;
   logic [7:0]       cmd_q, cmd_d;
   logic [4:0]       len_q, len_d;
   logic [4:0]       idx_q, idx_d;
   logic [7:0]       xor_q, xor_d;
   logic [127:0]     stage_q, stage_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_chk_q, err_chk_d;
   logic             err_len_q, err_len_d;
   logic             err_to_q, err_to_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       out_cmd_q, out_cmd_d;
   logic [4:0]       out_len_q, out_len_d;
   logic [127:0]     out_pay_q, out_pay_d;
   logic [7:0]       drop_q, drop_d;
   logic             timeout_hit;
   logic             frame_good;
   logic [7:0]       rx_byte;

   assign rx_byte = bus.io_rxByte_bits;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         xor_q       <= '0;
         stage_q     <= '0;
         cnt_q       <= '0;
         err_chk_q   <= 1'b0;
         err_len_q   <= 1'b0;
         err_to_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_cmd_q   <= '0;
         out_len_q   <= '0;
         out_pay_q   <= '0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         xor_q       <= xor_d;
         stage_q     <= stage_d;
         cnt_q       <= cnt_d;
         err_chk_q   <= err_chk_d;
         err_len_q   <= err_len_d;
         err_to_q    <= err_to_d;
         out_valid_q <= out_valid_d;
         out_cmd_q   <= out_cmd_d;
         out_len_q   <= out_len_d;
         out_pay_q   <= out_pay_d;
         drop_q      <= drop_d;
      end
   end

   // A timeout forces the parser back to IDLE first, so a byte landing on that cycle is parsed as if idle.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      len_d       = len_q;
      idx_d       = idx_q;
      xor_d       = xor_q;
      stage_d     = stage_q;
      cnt_d       = cnt_q;
      err_chk_d   = 1'b0;
      err_len_d   = 1'b0;
      err_to_d    = 1'b0;
      frame_good  = 1'b0;
      eff_state   = state_q;
      timeout_hit = (state_q != ST_IDLE) && (cnt_q == TO_LAST);

      if (state_q != ST_IDLE) cnt_d = cnt_q + CNT_W'(1);

      if (timeout_hit) begin
         err_to_d  = 1'b1;
         eff_state = ST_IDLE;
         state_d   = ST_IDLE;
         cnt_d     = '0;
      end

      if (bus.io_rxByte_valid) begin
         cnt_d = '0;
         case (eff_state)
            ST_IDLE: begin
               if (rx_byte == SYNC_BYTE) state_d = ST_CMD;
            end
            ST_CMD: begin
               cmd_d   = rx_byte;
               xor_d   = rx_byte;
               stage_d = '0;
               idx_d   = '0;
               state_d = ST_LEN;
            end
            ST_LEN: begin
               xor_d = xor_q ^ rx_byte;
               len_d = rx_byte[4:0];
               if (rx_byte > 8'd16) begin
                  err_len_d = 1'b1;
                  state_d   = ST_IDLE;
               end else if (rx_byte == 8'd0) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               stage_d[{idx_q[3:0], 3'b000} +: 8] = rx_byte;
               xor_d = xor_q ^ rx_byte;
               idx_d = idx_q + 5'd1;
               if ((idx_q + 5'd1) == len_q) state_d = ST_CHECK;
            end
            ST_CHECK: begin
               state_d = ST_IDLE;
               if (rx_byte != xor_q) err_chk_d  = 1'b1;
               else                  frame_good = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // A completing frame may replace the held one only when the held one is absent or accepted now.
   always_comb begin
      out_valid_d = out_valid_q;
      out_cmd_d   = out_cmd_q;
      out_len_d   = out_len_q;
      out_pay_d   = out_pay_q;
      drop_d      = drop_q;
      if (frame_good) begin
         if (!out_valid_q || bus.io_frame_ready) begin
            out_valid_d = 1'b1;
            out_cmd_d   = cmd_q;
            out_len_d   = len_q;
            out_pay_d   = stage_q;
         end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end else if (out_valid_q && bus.io_frame_ready) begin
         out_valid_d = 1'b0;
      end
   end

   assign bus.io_frame_valid   = out_valid_q;
   assign bus.io_frame_cmd     = out_cmd_q;
   assign bus.io_frame_len     = out_len_q;
   assign bus.io_frame_payload = out_pay_q;
   assign bus.io_errChecksum   = err_chk_q;
   assign bus.io_errLength     = err_len_q;
   assign bus.io_errTimeout    = err_to_q;
   assign bus.io_dropCount     = drop_q;
   assign bus.io_busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: directed vector table, handshake/timeout/reset sequences,
// and a random byte stream compared with a frame-level reference parser.
module tb_uart_frame_decoder;
   typedef struct packed {
      logic [7:0]   cmd;
      logic [4:0]   len;
      logic [127:0] pay;
   } frm_t;

   typedef struct {
      int           n;
      logic [63:0]  bytes;
      bit           frame;
      logic [7:0]   cmd;
      logic [4:0]   len;
      logic [127:0] pay;
      int           dchk;
      int           dlen;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   n_chk = 0;
   int   n_len = 0;
   int   n_to  = 0;
   frm_t obs_q[$];
   frm_t exp_q[$];
   logic [7:0] stream[$];
   vec_t vecs[6];

   always #5 clk = ~clk;

   uart_frame_decoder_if bus ();

   uart_frame_decoder #(
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   always @(negedge clk) begin
      if (bus.io_frame_valid && bus.io_frame_ready)
         obs_q.push_back({bus.io_frame_cmd, bus.io_frame_len, bus.io_frame_payload});
      if (bus.io_errChecksum) n_chk++;
      if (bus.io_errLength)   n_len++;
      if (bus.io_errTimeout)  n_to++;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      bus.io_rxByte_valid = 1'b1;
      bus.io_rxByte_bits  = b;
      @(posedge clk);
      #1;
      bus.io_rxByte_valid = 1'b0;
      bus.io_rxByte_bits  = 8'($urandom);
   endtask

   task automatic send_good(input logic [7:0] cmd, input logic [7:0] p0, input int len);
      send(8'hA5);
      send(cmd);
      send(8'(len));
      if (len == 1) send(p0);
      send((len == 1) ? (cmd ^ 8'(len) ^ p0) : (cmd ^ 8'(len)));
   endtask

   // Frame-level reading of the byte stream: find SYNC, then take CMD, LEN, payload and CHK.
   task automatic ref_parse(output int e_chk, output int e_len);
      int i;
      int len;
      logic [7:0] cmd;
      logic [7:0] x;
      logic [127:0] pay;
      e_chk = 0;
      e_len = 0;
      exp_q.delete();
      i = 0;
      while (i < stream.size()) begin
         if (stream[i] != 8'hA5) begin
            i++;
            continue;
         end
         if (i + 2 >= stream.size()) break;
         cmd = stream[i+1];
         len = int'(stream[i+2]);
         if (len > 16) begin
            e_len++;
            i += 3;
            continue;
         end
         if (i + 3 + len >= stream.size()) break;
         x   = cmd ^ 8'(len);
         pay = '0;
         for (int k = 0; k < len; k++) begin
            pay[8*k +: 8] = stream[i+3+k];
            x = x ^ stream[i+3+k];
         end
         if (stream[i+3+len] == x) exp_q.push_back({cmd, 5'(len), pay});
         else                      e_chk++;
         i += 4 + len;
      end
   endtask

   initial begin
      int f0, c0, l0, t0, k, d0;
      int e_chk, e_len;
      int kind, len;
      logic [7:0] cmd, x, b;
      frm_t f;

      vecs[0] = '{6, 64'hA5_01_02_10_20_33, 1'b1, 8'h01, 5'd2, 128'h2010, 0, 0};
      vecs[1] = '{4, 64'hA5_07_00_07,       1'b1, 8'h07, 5'd0, 128'h0,    0, 0};
      vecs[2] = '{4, 64'hA5_07_00_06,       1'b0, 8'h00, 5'd0, 128'h0,    1, 0};
      vecs[3] = '{3, 64'hA5_01_11,          1'b0, 8'h00, 5'd0, 128'h0,    0, 1};
      vecs[4] = '{5, 64'hA5_01_01_FF_FF,    1'b1, 8'h01, 5'd1, 128'hFF,   0, 0};
      vecs[5] = '{6, 64'h3C_A5_03_01_A5_A7, 1'b1, 8'h03, 5'd1, 128'hA5,   0, 0};

      rst = 1'b1;
      bus.io_rxByte_valid = 1'b0;
      bus.io_rxByte_bits  = 8'h00;
      bus.io_frame_ready  = 1'b1;
      step(3);
      check("reset valid", 128'(bus.io_frame_valid), 128'(0));
      check("reset cmd", 128'(bus.io_frame_cmd), 128'(0));
      check("reset len", 128'(bus.io_frame_len), 128'(0));
      check("reset payload", bus.io_frame_payload, 128'(0));
      check("reset errs", 128'({bus.io_errChecksum, bus.io_errLength, bus.io_errTimeout}), 128'(0));
      check("reset drop", 128'(bus.io_dropCount), 128'(0));
      check("reset busy", 128'(bus.io_busy), 128'(0));
      rst = 1'b0;
      step(2);

      for (int v = 0; v < 6; v++) begin
         f0 = obs_q.size();
         c0 = n_chk;
         l0 = n_len;
         for (int i = 0; i < vecs[v].n; i++) send(vecs[v].bytes[8*(vecs[v].n-1-i) +: 8]);
         step(3);
         check($sformatf("vec%0d frames", v), 128'(obs_q.size() - f0), 128'(vecs[v].frame));
         if (vecs[v].frame && obs_q.size() > f0) begin
            f = obs_q[obs_q.size()-1];
            check($sformatf("vec%0d cmd", v), 128'(f.cmd), 128'(vecs[v].cmd));
            check($sformatf("vec%0d len", v), 128'(f.len), 128'(vecs[v].len));
            check($sformatf("vec%0d payload", v), f.pay, vecs[v].pay);
         end
         check($sformatf("vec%0d errChecksum", v), 128'(n_chk - c0), 128'(vecs[v].dchk));
         check($sformatf("vec%0d errLength", v), 128'(n_len - l0), 128'(vecs[v].dlen));
         check($sformatf("vec%0d valid low", v), 128'(bus.io_frame_valid), 128'(0));
         check($sformatf("vec%0d busy", v), 128'(bus.io_busy), 128'(0));
      end

      // Timeout 100 cycles after the last byte
      t0 = n_to;
      send(8'hA5);
      send(8'h01);
      k = 0;
      while (k < 200) begin
         @(posedge clk);
         k++;
         #1;
         if (bus.io_errTimeout) break;
      end
      check("timeout cycle", 128'(k), 128'(100));
      check("timeout busy", 128'(bus.io_busy), 128'(0));
      step(2);
      check("timeout count", 128'(n_to - t0), 128'(1));

      // A SYNC byte landing on the timeout cycle starts a new frame
      t0 = n_to;
      f0 = obs_q.size();
      send(8'hA5);
      send(8'h01);
      step(99);
      send(8'hA5);
      check("timeout+sync busy", 128'(bus.io_busy), 128'(1));
      send(8'h02);
      send(8'h00);
      send(8'h02);
      step(3);
      check("timeout+sync pulses", 128'(n_to - t0), 128'(1));
      check("timeout+sync frames", 128'(obs_q.size() - f0), 128'(1));
      if (obs_q.size() > f0) check("timeout+sync cmd", 128'(obs_q[obs_q.size()-1].cmd), 128'(8'h02));

      // Output busy: second good frame is dropped, first is held
      bus.io_frame_ready = 1'b0;
      f0 = obs_q.size();
      d0 = int'(bus.io_dropCount);
      send_good(8'h01, 8'h00, 0);
      send_good(8'h02, 8'h55, 1);
      step(2);
      check("drop count", 128'(int'(bus.io_dropCount) - d0), 128'(1));
      check("held valid", 128'(bus.io_frame_valid), 128'(1));
      check("held cmd", 128'(bus.io_frame_cmd), 128'(8'h01));
      bus.io_frame_ready = 1'b1;
      step(2);
      check("drop accept valid", 128'(bus.io_frame_valid), 128'(0));
      check("drop frames", 128'(obs_q.size() - f0), 128'(1));
      if (obs_q.size() > f0) check("drop kept cmd", 128'(obs_q[obs_q.size()-1].cmd), 128'(8'h01));

      // Accept of the held frame on the same cycle the next frame completes
      bus.io_frame_ready = 1'b0;
      f0 = obs_q.size();
      send_good(8'h04, 8'hAA, 1);
      send(8'hA5);
      send(8'h05);
      send(8'h00);
      bus.io_frame_ready = 1'b1;
      send(8'h05);
      check("swap valid", 128'(bus.io_frame_valid), 128'(1));
      check("swap cmd", 128'(bus.io_frame_cmd), 128'(8'h05));
      step(3);
      check("swap frames", 128'(obs_q.size() - f0), 128'(2));
      if (obs_q.size() >= f0 + 2) begin
         check("swap first", 128'(obs_q[f0]), 128'({8'h04, 5'd1, 128'hAA}));
         check("swap second", 128'(obs_q[f0+1]), 128'({8'h05, 5'd0, 128'h0}));
      end
      check("swap no drop", 128'(int'(bus.io_dropCount) - d0), 128'(1));

      // Reset while a frame is held and another is half received
      bus.io_frame_ready = 1'b0;
      send_good(8'h09, 8'h00, 0);
      send(8'hA5);
      send(8'h01);
      send(8'h03);
      send(8'h11);
      rst = 1'b1;
      step(1);
      check("midrst valid", 128'(bus.io_frame_valid), 128'(0));
      check("midrst data", 128'({bus.io_frame_cmd, bus.io_frame_len, bus.io_frame_payload}), 128'(0));
      check("midrst drop", 128'(bus.io_dropCount), 128'(0));
      check("midrst busy", 128'(bus.io_busy), 128'(0));
      rst = 1'b0;
      bus.io_frame_ready = 1'b1;
      f0 = obs_q.size();
      c0 = n_chk;
      l0 = n_len;
      t0 = n_to;
      send(8'h22);
      send(8'h33);
      step(120);
      check("midrst frames", 128'(obs_q.size() - f0), 128'(0));
      check("midrst errs", 128'((n_chk - c0) + (n_len - l0) + (n_to - t0)), 128'(0));

      // Random stream against the reference parser
      stream.delete();
      for (int c = 0; c < 40; c++) begin
         kind = $urandom_range(0, 3);
         if (kind <= 1) begin
            cmd = 8'($urandom);
            len = $urandom_range(0, 16);
            x   = cmd ^ 8'(len);
            stream.push_back(8'hA5);
            stream.push_back(cmd);
            stream.push_back(8'(len));
            for (int p = 0; p < len; p++) begin
               b = 8'($urandom);
               stream.push_back(b);
               x = x ^ b;
            end
            stream.push_back((kind == 0) ? x : (x ^ 8'($urandom_range(1, 255))));
         end else if (kind == 2) begin
            stream.push_back(8'hA5);
            stream.push_back(8'($urandom));
            stream.push_back(8'($urandom_range(17, 255)));
         end else begin
            b = 8'($urandom);
            stream.push_back((b == 8'hA5) ? 8'h5A : b);
         end
      end
      ref_parse(e_chk, e_len);
      f0 = obs_q.size();
      c0 = n_chk;
      l0 = n_len;
      t0 = n_to;
      d0 = int'(bus.io_dropCount);
      foreach (stream[i]) begin
         send(stream[i]);
         step($urandom_range(0, 3));
      end
      step(5);
      check("rand frames", 128'(obs_q.size() - f0), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && f0 + i < obs_q.size(); i++)
         check($sformatf("rand frame%0d", i), 128'(obs_q[f0+i]), 128'(exp_q[i]));
      check("rand errChecksum", 128'(n_chk - c0), 128'(e_chk));
      check("rand errLength", 128'(n_len - l0), 128'(e_len));
      check("rand errTimeout", 128'(n_to - t0), 128'(0));
      check("rand drop", 128'(int'(bus.io_dropCount) - d0), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
